lvds_word_align: RTL and testbench

LVDS_WORD_ALIGN -- requirements
Module: lvds_word_align

---
 rtl/lvds_pkg.sv | 18 +
 rtl/lvds_lane_align.sv | 113 +++++++++++
 rtl/lvds_word_align.sv | 79 +++++++
 tb/tb_lvds_word_align.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS word aligner: per-lane FSM state encoding.
package lvds_pkg;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_COMPARE_ENC = 3'd1;
  localparam logic [2:0] ST_WAIT_ENC    = 3'd2;
  localparam logic [2:0] ST_LOCKED_ENC  = 3'd3;
  localparam logic [2:0] ST_FAIL_ENC    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_COMPARE = ST_COMPARE_ENC,
    ST_WAIT    = ST_WAIT_ENC,
    ST_LOCKED  = ST_LOCKED_ENC,
    ST_FAIL    = ST_FAIL_ENC
  } lane_state_e;

endpackage

// File: rtl/lvds_lane_align.sv
// Single-lane word aligner: compares the registered lane word against the
// training pattern and issues bitslip pulses until locked or out of slips.
module lvds_lane_align
  import lvds_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int SLIP_WAIT  = 4,
  parameter int MATCH_CNT  = 3,
  parameter int MAX_SLIPS  = 2 * DATA_WIDTH,
  parameter int SCW        = $clog2(MAX_SLIPS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_bit_align_done,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_pattern,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bitslip,
  output logic                  o_locked,
  output logic                  o_fail,
  output logic [SCW-1:0]        o_slip_count
);

  localparam int MCW = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;
  localparam int WCW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam logic [MCW-1:0] MATCH_LAST = MCW'(MATCH_CNT - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(SLIP_WAIT - 1);
  localparam logic [SCW-1:0] SLIP_MAX   = SCW'(MAX_SLIPS);
  localparam logic [SCW-1:0] SLIP_ONE   = SCW'(1);
  localparam logic [MCW-1:0] MATCH_ONE  = MCW'(1);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);

  lane_state_e     r_state;
  logic [MCW-1:0]  r_match_cnt;
  logic [WCW-1:0]  r_wait_cnt;
  logic [SCW-1:0]  r_slip_cnt;
  logic            r_bitslip;
  logic            r_locked;
  logic            r_fail;
  logic            w_match;

  assign w_match = (i_data == i_pattern);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_match_cnt <= '0;
      r_wait_cnt  <= '0;
      r_slip_cnt  <= '0;
      r_bitslip   <= 1'b0;
      r_locked    <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_bitslip <= 1'b0;
      // Losing bit alignment overrides everything else in the lane.
      if (!i_bit_align_done) begin
        r_state  <= ST_IDLE;
        r_locked <= 1'b0;
        r_fail   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_LOCKED, ST_FAIL: begin
            if (i_start) begin
              r_state     <= ST_COMPARE;
              r_slip_cnt  <= '0;
              r_match_cnt <= '0;
              r_locked    <= 1'b0;
              r_fail      <= 1'b0;
            end
          end
          ST_COMPARE: begin
            if (w_match) begin
              if (r_match_cnt == MATCH_LAST) begin
                r_state     <= ST_LOCKED;
                r_locked    <= 1'b1;
                r_match_cnt <= '0;
              end else begin
                r_match_cnt <= r_match_cnt + MATCH_ONE;
              end
            end else begin
              r_match_cnt <= '0;
              if (r_slip_cnt < SLIP_MAX) begin
                r_bitslip  <= 1'b1;
                r_slip_cnt <= r_slip_cnt + SLIP_ONE;
                r_wait_cnt <= '0;
                r_state    <= ST_WAIT;
              end else begin
                r_state <= ST_FAIL;
                r_fail  <= 1'b1;
              end
            end
          end
          ST_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) begin
              r_state <= ST_COMPARE;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_bitslip    = r_bitslip;
  assign o_locked     = r_locked;
  assign o_fail       = r_fail;
  assign o_slip_count = r_slip_cnt;

endmodule

// File: rtl/lvds_word_align.sv
// Multi-lane LVDS word aligner: registers the incoming lane words once and
// runs an independent alignment FSM per lane, plus registered summary flags.
module lvds_word_align
  import lvds_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int LANES      = 4,
  parameter int SLIP_WAIT  = 4,
  parameter int MATCH_CNT  = 3,
  parameter int MAX_SLIPS  = 2 * DATA_WIDTH
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [LANES-1:0]                         bit_align_done,
  input  logic                                     start,
  input  logic [DATA_WIDTH-1:0]                    pattern,
  input  logic [LANES*DATA_WIDTH-1:0]              data_in,
  output logic [LANES-1:0]                         bitslip,
  output logic [LANES-1:0]                         lane_locked,
  output logic [LANES-1:0]                         lane_fail,
  output logic                                     all_locked,
  output logic                                     all_done,
  output logic [LANES*$clog2(MAX_SLIPS+1)-1:0]     slip_count
);

  localparam int SCW = $clog2(MAX_SLIPS + 1);

  logic [LANES*DATA_WIDTH-1:0] r_data;
  logic [LANES-1:0]            w_locked;
  logic [LANES-1:0]            w_fail;
  logic                        r_all_locked;
  logic                        r_all_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= data_in;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lvds_lane_align #(
      .DATA_WIDTH (DATA_WIDTH),
      .SLIP_WAIT  (SLIP_WAIT),
      .MATCH_CNT  (MATCH_CNT),
      .MAX_SLIPS  (MAX_SLIPS),
      .SCW        (SCW)
    ) u_lane (
      .clk              (clk),
      .rst              (rst),
      .i_bit_align_done (bit_align_done[g]),
      .i_start          (start),
      .i_pattern        (pattern),
      .i_data           (r_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_bitslip        (bitslip[g]),
      .o_locked         (w_locked[g]),
      .o_fail           (w_fail[g]),
      .o_slip_count     (slip_count[g*SCW +: SCW])
    );
  end

  // Summary flags trail the per-lane status by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_all_locked <= 1'b0;
      r_all_done   <= 1'b0;
    end else begin
      r_all_locked <= &w_locked;
      r_all_done   <= &(w_locked | w_fail);
    end
  end

  assign lane_locked = w_locked;
  assign lane_fail   = w_fail;
  assign all_locked  = r_all_locked;
  assign all_done    = r_all_done;

endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align with a behavioural deserialiser that
// rotates each lane's word by one bit per bitslip pulse.
module tb_lvds_word_align;

  localparam int DW  = 10;
  localparam int NL  = 4;
  localparam int SW  = 4;
  localparam int MC  = 3;
  localparam int MS  = 2 * DW;
  localparam int SCW = $clog2(MS + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NL-1:0]        bit_align_done = '1;
  logic                 start = 1'b0;
  logic [DW-1:0]        pattern = 10'h2C7;
  logic [NL*DW-1:0]     data_in = '0;
  logic [NL-1:0]        bitslip;
  logic [NL-1:0]        lane_locked;
  logic [NL-1:0]        lane_fail;
  logic                 all_locked;
  logic                 all_done;
  logic [NL*SCW-1:0]    slip_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int rot       [NL];
  int pulses    [NL];
  logic prev_bs [NL];
  logic rnd_lane[NL];
  logic glitch  [NL];
  logic track   [NL];
  int dbl_pulse = 0;
  int p0_cyc [8];
  int p0_n = 0;

  lvds_word_align dut (
    .clk            (clk),
    .rst            (rst),
    .bit_align_done (bit_align_done),
    .start          (start),
    .pattern        (pattern),
    .data_in        (data_in),
    .bitslip        (bitslip),
    .lane_locked    (lane_locked),
    .lane_fail      (lane_fail),
    .all_locked     (all_locked),
    .all_done       (all_done),
    .slip_count     (slip_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] p, input int r);
    logic [DW-1:0] res;
    res = (p << r) | (p >> (DW - r));
    return res;
  endfunction

  task automatic drive_data();
    logic [DW-1:0] w;
    for (int l = 0; l < NL; l++) begin
      if (rnd_lane[l]) begin
        w = DW'($urandom_range(0, (1 << DW) - 1));
        if (w == pattern) w = w ^ 10'h001;
      end else begin
        w = rotl(pattern, rot[l]);
      end
      if (glitch[l]) w = ~w;
      data_in[l*DW +: DW] = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int l = 0; l < NL; l++) begin
      if (bitslip[l]) begin
        if (prev_bs[l]) dbl_pulse++;
        pulses[l]++;
        if (l == 0 && p0_n < 8) begin
          p0_cyc[p0_n] = cyc;
          p0_n++;
        end
        if (track[l]) rot[l] = (rot[l] + DW - 1) % DW;
      end
      prev_bs[l] = bitslip[l];
    end
    drive_data();
  endtask

  task automatic clr_stats();
    for (int l = 0; l < NL; l++) pulses[l] = 0;
    p0_n = 0;
    dbl_pulse = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [SCW-1:0] sc(input int l);
    return slip_count[l*SCW +: SCW];
  endfunction

  initial begin
    int n;
    for (int l = 0; l < NL; l++) begin
      rot[l] = 0; pulses[l] = 0; prev_bs[l] = 1'b0;
      rnd_lane[l] = 1'b0; glitch[l] = 1'b0; track[l] = 1'b1;
    end
    drive_data();
    #12;
    check_val("rst_bitslip", bitslip, 0);
    check_val("rst_locked", lane_locked, 0);
    check_val("rst_fail", lane_fail, 0);
    check_val("rst_all_done", all_done, 0);
    check_val("rst_slipcnt", slip_count, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check_val("norst_start_locked", lane_locked, 0);
    check_val("norst_start_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);

    // Aligned on every lane: lock with no slips.
    clr_stats();
    pulse_start();
    n = 0;
    while (!all_locked && n < 12) begin tick(); n++; end
    check_val("A_all_locked", all_locked, 1);
    check_val("A_latency_ok", n <= MC + 2, 1);
    check_val("A_no_slips", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);

    // Lane 0 rotated by three bits.
    rot[0] = 3;
    tick();
    clr_stats();
    pulse_start();
    tick();
    check_val("B_restart_clears", all_locked, 0);
    n = 0;
    while (!all_locked && n < 200) begin tick(); n++; end
    check_val("B_all_locked", all_locked, 1);
    check_val("B_pulses0", pulses[0], 3);
    check_val("B_gap1", p0_cyc[1] - p0_cyc[0], SW + 1);
    check_val("B_gap2", p0_cyc[2] - p0_cyc[1], SW + 1);
    check_val("B_slipcnt0", sc(0), 3);
    check_val("B_other_pulses", pulses[1] + pulses[2] + pulses[3], 0);

    // Lane 2 never sees the pattern.
    rnd_lane[2] = 1'b1;
    rot[0] = 1;
    tick();
    clr_stats();
    pulse_start();
    tick();
    check_val("C_done_clears", all_done, 0);
    n = 0;
    while (!all_done && n < 400) begin tick(); n++; end
    check_val("C_all_done", all_done, 1);
    check_val("C_all_locked", all_locked, 0);
    check_val("C_pulses2", pulses[2], 20);
    check_val("C_fail", lane_fail, 4'b0100);
    check_val("C_locked", lane_locked, 4'b1011);
    check_val("C_slipcnt2", sc(2), 20);
    check_val("C_slipcnt0", sc(0), 1);
    check_val("C_double_pulse", dbl_pulse, 0);

    // One corrupted word on lane 1 after two matches.
    rnd_lane[2] = 1'b0;
    track[1] = 1'b0;
    tick();
    clr_stats();
    pulse_start();
    tick();
    n = 1;
    glitch[1] = 1'b1;
    drive_data();
    tick();
    n = 2;
    glitch[1] = 1'b0;
    drive_data();
    while (!lane_locked[1] && n < 40) begin tick(); n++; end
    check_val("D_lock_cycle", n, 10);
    check_val("D_pulses1", pulses[1], 1);
    check_val("D_slipcnt1", sc(1), 1);
    track[1] = 1'b1;
    n = 0;
    while (!all_locked && n < 10) begin tick(); n++; end
    check_val("D_all_locked", all_locked, 1);

    // Reset in the middle of a WAIT.
    rot[3] = 2;
    tick();
    clr_stats();
    pulse_start();
    n = 0;
    while (pulses[3] == 0 && n < 20) begin tick(); n++; end
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_val("E_rst_locked", lane_locked, 0);
    check_val("E_rst_all_locked", all_locked, 0);
    check_val("E_rst_slipcnt", slip_count, 0);
    check_val("E_rst_bitslip", bitslip, 0);
    #2;
    rst = 1'b0;
    clr_stats();
    for (int i = 0; i < 15; i++) tick();
    check_val("E_idle_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
    check_val("E_idle_done", all_done, 0);
    pulse_start();
    n = 0;
    while (!all_locked && n < 100) begin tick(); n++; end
    check_val("E_relock", all_locked, 1);
    check_val("E_pulses3", pulses[3], 1);

    // Drop bit alignment on lane 1 while locked.
    bit_align_done[1] = 1'b0;
    tick();
    check_val("F_lane1_drop", lane_locked, 4'b1101);
    check_val("F_all_locked_lag", all_locked, 1);
    tick();
    check_val("F_all_locked_clr", all_locked, 0);
    bit_align_done[1] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_val("F_stays_idle", lane_locked[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
